// File: rtl/apb_slave_regbank.sv
// APB slave register bank: DEPTH-1 read/write words plus a read-only transfer
// counter in the top word, with programmable wait states and error response.
module apb_slave_regbank #(
    parameter int SEL_BIT     = 0,
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic [2:0]  psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] pr_data,
    output logic        pready,
    output logic        pslverr
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t         r_state;
    logic [25:0]    r_addr;
    logic           r_write;
    logic [31:0]    r_wdata;
    logic [3:0]     r_wcnt;
    // Top word doubles as the transfer counter; the error decode keeps writes off it.
    logic [31:0]    r_mem [DEPTH];

    logic           w_sel;
    logic [AW-1:0]  w_idx;
    logic           w_err;
    logic           w_ready;
    logic           w_unused;

    assign w_sel    = psel[SEL_BIT];
    assign w_idx    = r_addr[2 +: AW];
    assign w_ready  = (r_state == S_ACCESS) && (r_wcnt == 4'd0);
    assign w_err    = (r_addr[1:0] != 2'b00)
                    | (r_addr >= 26'(DEPTH * 4))
                    | (r_write && (w_idx == AW'(DEPTH - 1)));
    assign w_unused = ^{paddr[31:26], psel};

    assign pready   = w_ready;
    assign pslverr  = w_ready & w_err;

    always_comb begin
        pr_data = '0;
        if (w_ready && !r_write && !w_err) begin
            pr_data = r_mem[w_idx];
        end
    end

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_wcnt  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_sel && !penable) begin
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_addr  <= paddr[25:0];
                    r_write <= pwrite;
                    r_wdata <= pwdata;
                    r_wcnt  <= 4'(WAIT_CYCLES);
                    if (!w_sel) begin
                        r_state <= S_IDLE;
                    end else if (penable) begin
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (!w_sel) begin
                        r_state <= S_IDLE;
                    end else if (r_wcnt != 4'd0) begin
                        r_wcnt <= r_wcnt - 4'd1;
                    end else begin
                        if (r_write && !w_err) begin
                            r_mem[w_idx] <= r_wdata;
                        end
                        r_mem[DEPTH-1] <= r_mem[DEPTH-1] + 32'd1;
                        r_state <= penable ? S_IDLE : S_SETUP;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Bench for apb_slave_regbank: two instances (no wait states / three wait states)
// driven with directed and random APB transfers against a word-array model.
module tb_apb_slave_regbank;

    localparam int DEPTH = 16;
    localparam int W0 = 0;
    localparam int W1 = 3;
    localparam int SB0 = 0;
    localparam int SB1 = 2;

    logic        clk;
    logic        hresetn;
    logic [2:0]  psel_v    [2];
    logic        penable_v [2];
    logic        pwrite_v  [2];
    logic [31:0] paddr_v   [2];
    logic [31:0] pwdata_v  [2];
    logic [31:0] prdata_v  [2];
    logic        pready_v  [2];
    logic        pslverr_v [2];

    int checks = 0;
    int failures = 0;

    logic [31:0] m_mem [2][DEPTH];
    logic [31:0] m_cnt [2];

    apb_slave_regbank #(.SEL_BIT(SB0), .DEPTH(DEPTH), .WAIT_CYCLES(W0)) u_dut0 (
        .hclk(clk), .hresetn(hresetn), .psel(psel_v[0]), .penable(penable_v[0]),
        .pwrite(pwrite_v[0]), .paddr(paddr_v[0]), .pwdata(pwdata_v[0]),
        .pr_data(prdata_v[0]), .pready(pready_v[0]), .pslverr(pslverr_v[0])
    );

    apb_slave_regbank #(.SEL_BIT(SB1), .DEPTH(DEPTH), .WAIT_CYCLES(W1)) u_dut1 (
        .hclk(clk), .hresetn(hresetn), .psel(psel_v[1]), .penable(penable_v[1]),
        .pwrite(pwrite_v[1]), .paddr(paddr_v[1]), .pwdata(pwdata_v[1]),
        .pr_data(prdata_v[1]), .pready(pready_v[1]), .pslverr(pslverr_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int wait_of(input int k);
        return (k == 1) ? W1 : W0;
    endfunction

    function automatic logic [2:0] sel_of(input int k);
        return (k == 1) ? 3'(1 << SB1) : 3'(1 << SB0);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = '0;
            for (int i = 0; i < DEPTH; i++) m_mem[k][i] = '0;
        end
    endtask

    // Expected result of one completed transfer, then apply its side effects.
    task automatic model_xfer(input int k, input logic wr, input logic [31:0] addr,
                              input logic [31:0] data, output logic [31:0] exp_d,
                              output logic exp_e);
        int off;
        int idx;
        off = int'(addr[25:0]);
        idx = (off / 4) % DEPTH;
        exp_e = (off % 4 != 0) || (off >= DEPTH * 4) || (wr && idx == DEPTH - 1);
        exp_d = '0;
        if (!wr && !exp_e) exp_d = (idx == DEPTH - 1) ? m_cnt[k] : m_mem[k][idx];
        if (wr && !exp_e) m_mem[k][idx] = data;
        m_cnt[k] = m_cnt[k] + 32'd1;
    endtask

    task automatic idle_all();
        for (int k = 0; k < 2; k++) begin
            psel_v[k] = '0; penable_v[k] = 1'b0; pwrite_v[k] = 1'b0;
            paddr_v[k] = '0; pwdata_v[k] = '0;
        end
    endtask

    task automatic xfer(input int k, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data);
        logic [31:0] exp_d;
        logic        exp_e;
        int          waits;
        string       t;
        t = $sformatf("%s%0d@%h", wr ? "wr" : "rd", k, addr);
        model_xfer(k, wr, addr, data, exp_d, exp_e);
        @(negedge clk);
        psel_v[k] = sel_of(k); penable_v[k] = 1'b0;
        pwrite_v[k] = wr; paddr_v[k] = addr; pwdata_v[k] = data;
        @(negedge clk);
        penable_v[k] = 1'b1;
        check({t, "_setup_pready"}, 32'(pready_v[k]), 32'd0);
        @(negedge clk);
        waits = 0;
        while (pready_v[k] !== 1'b1 && waits < 40) begin
            check({t, "_wait_pslverr"}, 32'(pslverr_v[k]), 32'd0);
            waits++;
            @(negedge clk);
        end
        check({t, "_latency"}, 32'(waits), 32'(wait_of(k)));
        check({t, "_pready"}, 32'(pready_v[k]), 32'd1);
        check({t, "_pslverr"}, 32'(pslverr_v[k]), 32'(exp_e));
        check({t, "_rdata"}, prdata_v[k], exp_d);
        @(posedge clk);
        #1;
        psel_v[k] = '0; penable_v[k] = 1'b0;
        @(negedge clk);
        check({t, "_post_pready"}, 32'(pready_v[k]), 32'd0);
        check({t, "_post_rdata"}, prdata_v[k], 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        hresetn = 1'b0;
        repeat (2) @(negedge clk);
        hresetn = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int          k;
        int          r;
        logic        wr;

        idle_all();
        hresetn = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        for (int j = 0; j < 2; j++) begin
            check($sformatf("reset_pready%0d", j), 32'(pready_v[j]), 32'd0);
            check($sformatf("reset_pslverr%0d", j), 32'(pslverr_v[j]), 32'd0);
            check($sformatf("reset_rdata%0d", j), prdata_v[j], 32'd0);
        end
        hresetn = 1'b1;

        // Zero-wait write then read back.
        xfer(0, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF);
        xfer(0, 1'b0, 32'h0000_0008, 32'h0);

        // Three-wait read of a freshly reset word.
        xfer(1, 1'b0, 32'h0000_0004, 32'h0);

        // Error responses: misaligned, out of range, counter write.
        do_reset();
        for (int j = 0; j < 2; j++) begin
            xfer(j, 1'b1, 32'h0000_0002, 32'h1111_1111);
            xfer(j, 1'b1, 32'h0000_0040, 32'h2222_2222);
            xfer(j, 1'b0, 32'h0000_003C, 32'h0);
            xfer(j, 1'b0, 32'h0000_0000, 32'h0);
            xfer(j, 1'b1, 32'h0000_003C, 32'hFFFF_0000);
            xfer(j, 1'b0, 32'h0000_003C, 32'h0);
        end

        // Abort during wait states of a write to word 4.
        xfer(1, 1'b1, 32'h0000_0010, 32'hA5A5_0001);
        @(negedge clk);
        psel_v[1] = sel_of(1); penable_v[1] = 1'b0;
        pwrite_v[1] = 1'b1; paddr_v[1] = 32'h0000_0010; pwdata_v[1] = 32'h5A5A_0002;
        @(negedge clk);
        penable_v[1] = 1'b1;
        @(negedge clk);
        check("abort_wait_pready", 32'(pready_v[1]), 32'd0);
        psel_v[1] = '0; penable_v[1] = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("abort_idle_pready", 32'(pready_v[1]), 32'd0);
        end
        xfer(1, 1'b0, 32'h0000_0010, 32'h0);
        xfer(1, 1'b0, 32'h0000_003C, 32'h0);

        // Wrong select bit: no response, counter unchanged.
        @(negedge clk);
        psel_v[0] = 3'b100; pwrite_v[0] = 1'b1; paddr_v[0] = 32'h0000_0000;
        pwdata_v[0] = 32'hBAD0_BAD0; penable_v[0] = 1'b0;
        @(negedge clk);
        penable_v[0] = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("othersel_pready", 32'(pready_v[0]), 32'd0);
            check("othersel_pslverr", 32'(pslverr_v[0]), 32'd0);
        end
        idle_all();
        xfer(0, 1'b0, 32'h0000_0000, 32'h0);
        xfer(0, 1'b0, 32'h0000_003C, 32'h0);

        // Reset asserted in ACCESS of a write: transfer dropped, state cleared.
        xfer(1, 1'b1, 32'h0000_0014, 32'h1234_5678);
        @(negedge clk);
        psel_v[1] = sel_of(1); penable_v[1] = 1'b0;
        pwrite_v[1] = 1'b1; paddr_v[1] = 32'h0000_0018; pwdata_v[1] = 32'hCAFE_F00D;
        @(negedge clk);
        penable_v[1] = 1'b1;
        @(negedge clk);
        hresetn = 1'b0;
        @(negedge clk);
        check("rstmid_pready", 32'(pready_v[1]), 32'd0);
        check("rstmid_rdata", prdata_v[1], 32'd0);
        hresetn = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("rstmid_no_resume", 32'(pready_v[1]), 32'd0);
        end
        idle_all();
        model_reset();
        xfer(1, 1'b0, 32'h0000_0014, 32'h0);
        xfer(1, 1'b0, 32'h0000_0018, 32'h0);
        xfer(0, 1'b0, 32'h0000_0008, 32'h0);
        xfer(1, 1'b0, 32'h0000_003C, 32'h0);

        // Random traffic on both instances.
        for (int n = 0; n < 80; n++) begin
            k = int'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 7));
            a = 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
            if (r == 0) a = a | 32'($urandom_range(1, 3));
            if (r == 1) a = 32'(DEPTH * 4) + 32'($urandom_range(0, 200)) * 32'd4;
            a = a | ($urandom & 32'hFC00_0000);
            d = $urandom;
            xfer(k, wr, a, d);
        end
        for (int j = 0; j < 2; j++) xfer(j, 1'b0, 32'h0000_003C, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
